// File: rtl/elink_rec_deframer.sv
// E-link receive deframer: 10-bit flagged chars -> 76-bit frame.
// Optional ELINK_DEFRAMER_ERR_CNT_EN adds a saturating err_cnt output.
module elink_rec_deframer (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  data_10bit_in,
  input  logic        data_valid_in,
  input  logic [7:0]  Kchar_sop,
  input  logic [7:0]  Kchar_eop,
  input  logic [7:0]  Kchar_comma,
  output logic [75:0] frame_out,
  output logic        frame_valid,
  output logic        frame_err,
`ifdef ELINK_DEFRAMER_ERR_CNT_EN
  output logic [7:0]  err_cnt,
`endif
  output logic [2:0]  err_code
);

  localparam logic [1:0] C_DATA  = 2'b00;
  localparam logic [1:0] C_EOP   = 2'b01;
  localparam logic [1:0] C_SOP   = 2'b10;
  localparam logic [1:0] C_COMMA = 2'b11;

  localparam logic [2:0] E_ORPHAN  = 3'd1;
  localparam logic [2:0] E_SHORT   = 3'd2;
  localparam logic [2:0] E_LONG    = 3'd3;
  localparam logic [2:0] E_RESTART = 3'd4;
  localparam logic [2:0] E_KCHAR   = 3'd5;
  localparam logic [2:0] E_PAD     = 3'd6;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PAYLOAD,
    S_WAIT
  } state_t;

  state_t      state, state_n;
  logic [3:0]  cnt, cnt_n;
  // slots 0..8 shift in from the bottom; slot 0 ends on top
  logic [71:0] asm_q, asm_n;
  logic [3:0]  nib, nib_n;
  logic [3:0]  pad, pad_n;
  logic [75:0] frame_n;
  logic        fv_n, fe_n;
  logic [2:0]  ec_n;
  logic [1:0]  code;
  logic [7:0]  byt;
  logic        kbad;

  assign code = data_10bit_in[9:8];
  assign byt  = data_10bit_in[7:0];

  // K-char byte must match the configured value for its code
  always_comb begin
    kbad = 1'b0;
    case (code)
      C_COMMA: kbad = (byt != Kchar_comma);
      C_SOP:   kbad = (byt != Kchar_sop);
      C_EOP:   kbad = (byt != Kchar_eop);
      default: kbad = 1'b0;
    endcase
  end

  // next-state, assembly and registered-output logic
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    asm_n   = asm_q;
    nib_n   = nib;
    pad_n   = pad;
    frame_n = frame_out;
    fv_n    = 1'b0;
    fe_n    = 1'b0;
    ec_n    = err_code;
    if (data_valid_in) begin
      if (kbad) begin
        fe_n    = 1'b1;
        ec_n    = E_KCHAR;
        state_n = S_IDLE;
        cnt_n   = 4'd0;
      end else begin
        unique case (state)
          S_IDLE: begin
            case (code)
              C_SOP: begin
                state_n = S_PAYLOAD;
                cnt_n   = 4'd0;
              end
              C_DATA, C_EOP: begin
                fe_n = 1'b1;
                ec_n = E_ORPHAN;
              end
              default: ;
            endcase
          end
          S_PAYLOAD: begin
            case (code)
              C_DATA: begin
                if (cnt == 4'd9) begin
                  nib_n   = byt[3:0];
                  pad_n   = byt[7:4];
                  cnt_n   = 4'd0;
                  state_n = S_WAIT;
                end else begin
                  asm_n = {asm_q[63:0], byt};
                  cnt_n = cnt + 4'd1;
                end
              end
              C_SOP: begin
                fe_n  = 1'b1;
                ec_n  = E_RESTART;
                cnt_n = 4'd0;
              end
              default: begin
                fe_n    = 1'b1;
                ec_n    = E_SHORT;
                cnt_n   = 4'd0;
                state_n = S_IDLE;
              end
            endcase
          end
          S_WAIT: begin
            case (code)
              C_EOP: begin
                if (pad == 4'd0) begin
                  fv_n    = 1'b1;
                  frame_n = {asm_q, nib};
                end else begin
                  fe_n = 1'b1;
                  ec_n = E_PAD;
                end
                state_n = S_IDLE;
              end
              C_SOP: begin
                fe_n    = 1'b1;
                ec_n    = E_RESTART;
                cnt_n   = 4'd0;
                state_n = S_PAYLOAD;
              end
              default: begin
                fe_n    = 1'b1;
                ec_n    = E_LONG;
                state_n = S_IDLE;
              end
            endcase
          end
          default: state_n = S_IDLE;
        endcase
      end
    end
  end

  // state, assembly and output registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= S_IDLE;
      cnt         <= 4'd0;
      asm_q       <= '0;
      nib         <= 4'd0;
      pad         <= 4'd0;
      frame_out   <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      err_code    <= 3'd0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      asm_q       <= asm_n;
      nib         <= nib_n;
      pad         <= pad_n;
      frame_out   <= frame_n;
      frame_valid <= fv_n;
      frame_err   <= fe_n;
      err_code    <= ec_n;
    end
  end

`ifdef ELINK_DEFRAMER_ERR_CNT_EN
  // saturating count of error pulses
  always_ff @(posedge clk) begin
    if (!rst)
      err_cnt <= 8'd0;
    else if (fe_n && err_cnt != 8'hFF)
      err_cnt <= err_cnt + 8'd1;
  end
`endif

endmodule

// File: tb/tb_elink_rec_deframer.sv
// Scoreboard bench for elink_rec_deframer.
// Stimulus pushes expected pulses; a negedge monitor pops and compares.
module tb_elink_rec_deframer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [9:0]  data_10bit_in = '0;
  logic        data_valid_in = 1'b0;
  logic [7:0]  Kchar_sop = 8'h3C;
  logic [7:0]  Kchar_eop = 8'hDC;
  logic [7:0]  Kchar_comma = 8'hBC;
  logic [75:0] frame_out;
  logic        frame_valid;
  logic        frame_err;
  logic [2:0]  err_code;
`ifdef ELINK_DEFRAMER_ERR_CNT_EN
  logic [7:0]  err_cnt;
`endif

  elink_rec_deframer dut (
    .clk           (clk),
    .rst           (rst),
    .data_10bit_in (data_10bit_in),
    .data_valid_in (data_valid_in),
    .Kchar_sop     (Kchar_sop),
    .Kchar_eop     (Kchar_eop),
    .Kchar_comma   (Kchar_comma),
    .frame_out     (frame_out),
    .frame_valid   (frame_valid),
    .frame_err     (frame_err),
`ifdef ELINK_DEFRAMER_ERR_CNT_EN
    .err_cnt       (err_cnt),
`endif
    .err_code      (err_code)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is_frame;
    logic [75:0] frame;
    logic [2:0]  code;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;

  localparam logic [1:0] DAT = 2'b00;
  localparam logic [1:0] EOP = 2'b01;
  localparam logic [1:0] SOP = 2'b10;
  localparam logic [1:0] COM = 2'b11;

  localparam logic [75:0] F_NOM = 76'h123456789ABCDEF0115;
  localparam logic [75:0] F_B   = 76'hA1A2A3A4A5A6A7A8A9C;

  logic [7:0] nom [10] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A,
                           8'hBC, 8'hDE, 8'hF0, 8'h11, 8'h05};
  logic [7:0] pb  [10] = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5,
                           8'hA6, 8'hA7, 8'hA8, 8'hA9, 8'h0C};

  task automatic push_frame(input logic [75:0] f);
    exp_t e;
    e.is_frame = 1'b1;
    e.frame = f;
    e.code = 3'd0;
    q.push_back(e);
  endtask

  task automatic push_err(input logic [2:0] c);
    exp_t e;
    e.is_frame = 1'b0;
    e.frame = '0;
    e.code = c;
    q.push_back(e);
  endtask

  task automatic check(input string name, input logic [75:0] act,
                       input logic [75:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic ch(input logic [1:0] c, input logic [7:0] b);
    data_10bit_in = {c, b};
    data_valid_in = 1'b1;
    @(posedge clk);
    #1;
    data_valid_in = 1'b0;
  endtask

  task automatic gap(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b [10], input int g);
    ch(SOP, 8'h3C);
    if (g > 0) gap(g);
    for (int i = 0; i < 10; i++) begin
      ch(DAT, b[i]);
      if (g > 0) gap(g);
    end
    ch(EOP, 8'hDC);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // monitor: pop expected pulse whenever the DUT raises one
  always @(negedge clk) begin
    if (rst) begin
      if (frame_valid && frame_err) begin
        checks++;
        failures++;
        $display("FAIL both_pulses: valid=1 err=1 required one only");
      end else if (frame_valid || frame_err) begin
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_pulse: valid=%0b err=%0b code=%0d",
                   frame_valid, frame_err, err_code);
        end else begin
          exp_t e;
          e = q.pop_front();
          if (e.is_frame != frame_valid) begin
            failures++;
            $display("FAIL pulse_kind: valid=%0b code=%0d required %s",
                     frame_valid, err_code,
                     e.is_frame ? "frame" : "error");
          end else if (e.is_frame && frame_out !== e.frame) begin
            failures++;
            $display("FAIL frame_data: got %h required %h",
                     frame_out, e.frame);
          end else if (!e.is_frame && err_code !== e.code) begin
            failures++;
            $display("FAIL err_code: got %0d required %0d",
                     err_code, e.code);
          end
        end
      end
    end
  end

  initial begin
    gap(2);
    check("rst_frame_out", frame_out, 76'd0);
    check("rst_valid", {75'd0, frame_valid}, 76'd0);
    check("rst_err", {75'd0, frame_err}, 76'd0);
    check("rst_code", {73'd0, err_code}, 76'd0);
    rst = 1'b1;
    gap(1);

    push_err(3'd1);
    ch(DAT, 8'h55);
    push_err(3'd1);
    ch(EOP, 8'hDC);

    ch(COM, 8'hBC);
    push_frame(F_NOM);
    send_frame(nom, 0);
    gap(2);
    check("nominal_hold", frame_out, F_NOM);

    ch(SOP, 8'h3C);
    for (int i = 0; i < 5; i++) ch(DAT, nom[i]);
    push_err(3'd2);
    ch(EOP, 8'hDC);
    gap(2);
    check("short_keeps_frame", frame_out, F_NOM);

    ch(SOP, 8'h3C);
    for (int i = 0; i < 10; i++) ch(DAT, nom[i]);
    push_err(3'd3);
    ch(DAT, 8'h77);

    ch(SOP, 8'h3C);
    for (int i = 0; i < 9; i++) ch(DAT, nom[i]);
    ch(DAT, 8'h15);
    push_err(3'd6);
    ch(EOP, 8'hDC);
    gap(2);
    check("pad_keeps_frame", frame_out, F_NOM);

    ch(SOP, 8'h3C);
    for (int i = 0; i < 3; i++) ch(DAT, nom[i]);
    push_err(3'd4);
    ch(SOP, 8'h3C);
    for (int i = 0; i < 10; i++) ch(DAT, pb[i]);
    push_frame(F_B);
    ch(EOP, 8'hDC);
    gap(2);
    check("restart_frame", frame_out, F_B);

    push_err(3'd5);
    ch(COM, 8'h00);
    gap(1);
    check("kchar_code_hold", {73'd0, err_code}, 76'd5);

    push_frame(F_NOM);
    send_frame(nom, 0);
    push_frame(F_B);
    send_frame(pb, 0);
    gap(2);

    push_frame(F_NOM);
    send_frame(nom, 3);
    gap(2);

    ch(SOP, 8'h3C);
    for (int i = 0; i < 4; i++) ch(DAT, nom[i]);
    do_reset();
    check("mid_rst_frame_out", frame_out, 76'd0);
    check("mid_rst_valid", {75'd0, frame_valid}, 76'd0);
    check("mid_rst_err", {75'd0, frame_err}, 76'd0);
    check("mid_rst_code", {73'd0, err_code}, 76'd0);
    rst = 1'b1;
    gap(1);
    push_frame(F_B);
    send_frame(pb, 0);
    gap(2);
    check("post_rst_code", {73'd0, err_code}, 76'd0);

`ifdef ELINK_DEFRAMER_ERR_CNT_EN
    check("cnt_start", {68'd0, err_cnt}, 76'd0);
    for (int i = 0; i < 300; i++) begin
      push_err(3'd1);
      ch(DAT, 8'h01);
    end
    gap(2);
    check("cnt_sat", {68'd0, err_cnt}, 76'd255);
    do_reset();
    check("cnt_rst", {68'd0, err_cnt}, 76'd0);
    rst = 1'b1;
    gap(1);
`endif

    gap(5);
    check("queue_drained", 76'(q.size()), 76'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
